// File: rtl/main_fsm.sv
// Moore sequencer for the multicycle ARM controller: walks one instruction through
// fetch/decode/execute and drives datapath selects plus raw write strobes.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic [3:0] State,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_e;

    state_e state_q;
    state_e state_d;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Op/Funct only matter in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR: begin
                if (Funct[0]) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_UNKNOWN:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore output decode; UNKNOWN and illegal codes leave everything at zero.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB   = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
            end
            S_EXECUTER: begin
                ALUOp     = 1'b1;
            end
            S_EXECUTEI: begin
                ALUSrcB   = 2'b01;
                ALUOp     = 1'b1;
            end
            S_ALUWB: begin
                RegW      = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            default: begin
                IRWrite   = 1'b0;
            end
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Randomized scoreboard bench for main_fsm: the stimulus side predicts per-cycle
// state and outputs from instruction class; a negedge monitor pops and compares.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] State;
    logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;

    main_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .State(State),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .Branch(Branch), .ALUOp(ALUOp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [12:0] row;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Row packing: {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,NextPC,RegW,MemW,Branch,ALUOp}
    function automatic logic [12:0] row_of(input int s);
        case (s)
            0:       return {1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            1:       return {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            2:       return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            3:       return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            4:       return {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            5:       return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            6:       return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            7:       return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            8:       return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            9:       return {1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            default: return 13'd0;
        endcase
    endfunction

    // Reference: the state walk of a whole instruction, from its class alone.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                             input int abort_at, input int rst_edges);
        int seq[$];
        case (op)
            2'b01:   seq = fn[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
            2'b00:   seq = fn[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
            2'b10:   seq = '{0, 1, 9};
            default: seq = '{0, 1, 10};
        endcase
        for (int k = 0; k < seq.size(); k++) begin
            if (seq[k] == 1 || seq[k] == 2) begin
                Op    = op;
                Funct = fn;
            end else begin
                Op    = 2'($urandom);
                Funct = 6'($urandom);
            end
            exp_q.push_back('{st: 4'(seq[k]), row: row_of(seq[k])});
            if (k == abort_at) begin
                reset = 1'b1;
                repeat (rst_edges) @(posedge clk);
                #1 reset = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_word(input logic [31:0] instr, input int abort_at, input int rst_edges);
        run_instr(instr[27:26], instr[25:20], abort_at, rst_edges);
    endtask

    // Monitor: compare every scheduled cycle mid-period.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (State !== e.st) begin
                n_fail++;
                $display("FAIL state: got %0d expected %0d at %0t", State, e.st, $time);
            end
            n_checks++;
            if ({IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp}
                    !== e.row) begin
                n_fail++;
                $display("FAIL outputs in state %0d: got %b expected %b at %0t", e.st,
                         {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW,
                          Branch, ALUOp}, e.row, $time);
            end
        end
    end

    initial begin
        int t;
        reset = 1'b1;
        Op    = 2'b00;
        Funct = 6'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_word(32'hE591_2004, -1, 0);  // LDR
        run_word(32'hE581_2004, -1, 0);  // STR
        run_word(32'hE081_2003, -1, 0);  // ADD reg
        run_word(32'hE281_2005, -1, 0);  // ADD imm
        run_word(32'hEA00_0002, -1, 0);  // B
        run_word(32'hEC00_0000, -1, 0);  // Op=11
        run_word(32'hE591_2004, 3, 2);   // reset held 2 edges in MEMREAD
        run_word(32'hE581_2004, 3, 1);   // reset pulse in MEMWRITE
        run_word(32'hE581_2004, -1, 0);  // full re-execution afterwards

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(9) == 0) begin
                run_instr(2'($urandom), 6'($urandom), int'($urandom_range(4)),
                          int'($urandom_range(2, 1)));
            end else begin
                run_instr(2'($urandom), 6'($urandom), -1, 0);
            end
        end
        run_word(32'hE281_2005, -1, 0);

        t = 0;
        while (exp_q.size() > 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
